reg_view_ctl: RTL and testbench
===============================

# reg_view_ctl

Button-driven controller that sequences the register-display path of the VGA register demo. It debounces the four board buttons once per video frame, runs a small mode state machine, and drives the `register`, `x_pos` and `y_pos` inputs of the register-display overlay. All changes are committed only at end of frame, so a frame is never drawn with a half-updated value or position.

## Interface
- `DEBOUNCE_FRAMES`, 3: consecutive sampled-high frames before a press is accepted (1..15).
- `REPEAT_FRAMES`, 8: frames between auto-repeat events while a button stays held (1..63).
- `X_INIT`, 100: reset value of `x_pos`.
- `Y_INIT`, 100: reset value of `y_pos`.
- `X_MAX`, 576: upper saturation limit of `x_pos`.
- `Y_MAX`, 464: upper saturation limit of `y_pos`.
- `POS_STEP`, 4: pixels moved per accepted up/down event.
- `px_clk` in 1: pixel clock; the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `endframe` in 1: end-of-frame level from the VGA endframe detector; may stay high several cycles.
- `btn_up`, `btn_down`, `btn_sel` in 1 each: raw asynchronous buttons, active-high.
- `register` out 8: value to display.
- `x_pos` out 10: display X origin.
- `y_pos` out 10: display Y origin.
- `mode` out 2: current mode (0 VALUE, 1 MOVE_X, 2 MOVE_Y), for an on-screen indicator.

## Operation
- Each button passes through a 2-flop synchronizer on `px_clk`.
- Frame tick: single-cycle pulse on the first `px_clk` cycle where registered `endframe` is 1 and its previous sample was 0.
- On every tick each button's 6-bit hold counter samples its synchronized level: if high, increments (saturating at 63); if low, clears to 0.
- Press event for a button when its counter becomes exactly `DEBOUNCE_FRAMES`.
- Mode FSM: VALUE -> MOVE_X -> MOVE_Y -> VALUE, advanced by one `btn_sel` press event; code 3 is unreachable and recovers to VALUE on the next tick.
- Up/down events act on the current mode:
  - VALUE: `register` +1 / -1, 8-bit modulo (255 + 1 = 0, 0 - 1 = 255).
  - MOVE_X / MOVE_Y: position ±`POS_STEP`, saturating at 0 and `X_MAX`/`Y_MAX`; computed with 11-bit intermediate, never wraps.
- Priority on the same tick: a `btn_sel` event wins; up/down events in that tick are discarded. Up and down events together cancel (no change).
- `btn_sel` never auto-repeats.

## Timing
- Reset (async assert, sync release): `register` = 0, `x_pos` = `X_INIT`, `y_pos` = `Y_INIT`, `mode` = 0, counters and synchronizers 0, no tick pending.
- Outputs change only on the `px_clk` edge following a frame tick (1 cycle latency tick -> output); they are stable for the whole visible frame.
- Button-to-output latency: 2 sync cycles + `DEBOUNCE_FRAMES` ticks + 1 cycle.
- `endframe` held high for many cycles yields exactly one tick. `endframe` high out of reset produces no tick until it goes low then high.
- Button released before reaching `DEBOUNCE_FRAMES` ticks: no event. Release and re-press restart counting from 0.
- Reset mid-frame or mid-hold: all state returns to reset values immediately; the held button must reach `DEBOUNCE_FRAMES` again after release of reset.

## Configuration
- `REG_VIEW_AUTOREPEAT_EN` defined: while up/down remains held after its press event, an additional event is generated every `REPEAT_FRAMES` ticks (counter values `DEBOUNCE_FRAMES + k*REPEAT_FRAMES`, k >= 1; the counter wraps its repeat phase instead of saturating). Same priority and cancel rules apply.
- Not defined: exactly one event per press; holding has no further effect. Repeat logic is not built.

## Test plan
- Reset then 10 ticks, no buttons -> `register`=0, `x_pos`=100, `y_pos`=100, `mode`=0 throughout.
- Hold `btn_up` for 3 ticks in VALUE -> `register` becomes 1 one cycle after the 3rd tick; held 2 ticks only -> stays 0.
- `register`=0, one `btn_down` press -> 255; `btn_sel` twice then `btn_down` presses from `y_pos`=100 -> 96, 92; from `y_pos`=2 -> 0 and stays 0.
- `btn_sel` and `btn_up` reaching debounce on the same tick in VALUE -> `mode`=1, `register` unchanged; `endframe` held high 500 cycles -> single tick counted.
- With `REG_VIEW_AUTOREPEAT_EN`, hold `btn_up` 27 ticks in VALUE -> `register` = 4 (events at ticks 3, 11, 19, 27); without macro -> `register` = 1.
- Assert `reset` while `btn_up` held at tick 2 of debounce and `x_pos`=120 -> all outputs return to reset values at once; no event until 3 further ticks after reset release.

Source files
------------

// File: rtl/reg_view_ctl.sv
// Button-driven mode/value/position controller for the register-display overlay.
// Optional auto-repeat on held up/down buttons is built when REG_VIEW_AUTOREPEAT_EN is defined.
module reg_view_ctl #(
  parameter int unsigned DEBOUNCE_FRAMES = 3,
  parameter int unsigned REPEAT_FRAMES   = 8,
  parameter int unsigned X_INIT          = 100,
  parameter int unsigned Y_INIT          = 100,
  parameter int unsigned X_MAX           = 576,
  parameter int unsigned Y_MAX           = 464,
  parameter int unsigned POS_STEP        = 4
) (
  input  logic       px_clk,
  input  logic       reset,
  input  logic       endframe,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  output logic [7:0] register,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    VALUE  = 2'd0,
    MOVE_X = 2'd1,
    MOVE_Y = 2'd2
  } mode_e;

  localparam logic [5:0]  DEB      = 6'(DEBOUNCE_FRAMES);
  localparam logic [5:0]  HOLD_MAX = 6'd63;
  localparam logic [10:0] STEP     = 11'(POS_STEP);
  localparam logic [10:0] XLIM     = 11'(X_MAX);
  localparam logic [10:0] YLIM     = 11'(Y_MAX);

  // Bit order for button vectors: 0 = up, 1 = down, 2 = sel.
  logic [2:0]      sync1_q, sync2_q;
  logic            ef_q, ef_prev_q;
  logic            tick;
  logic [2:0][5:0] hold_q, hold_d;
  logic [2:0]      press;
  logic            up_ev, dn_ev;

  mode_e       mode_q, mode_d;
  logic [7:0]  register_q, register_d;
  logic [9:0]  x_q, x_d, y_q, y_d;

  function automatic logic [9:0] step_pos(input logic [9:0] pos, input logic inc,
                                          input logic [10:0] lim);
    logic [10:0] wide;
    wide = {1'b0, pos};
    if (inc) begin
      wide = wide + STEP;
      if (wide > lim) wide = lim;
    end else if (wide < STEP) begin
      wide = '0;
    end else begin
      wide = wide - STEP;
    end
    return wide[9:0];
  endfunction

  always_comb begin
    tick   = ef_q & ~ef_prev_q;
    hold_d = hold_q;
    press  = '0;
    if (tick) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (!sync2_q[i]) hold_d[i] = '0;
        else if (hold_q[i] != HOLD_MAX) hold_d[i] = hold_q[i] + 6'd1;
        press[i] = sync2_q[i] && (hold_d[i] == DEB);
      end
    end
  end

`ifdef REG_VIEW_AUTOREPEAT_EN
  localparam logic [5:0] RPT_LAST = 6'(REPEAT_FRAMES - 1);

  // Repeat phase counts ticks since the last up/down event, independent of the saturating hold count.
  logic [1:0][5:0] rpt_q, rpt_d;
  logic [1:0]      rpt_ev;

  always_comb begin
    rpt_d  = rpt_q;
    rpt_ev = '0;
    if (tick) begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (!sync2_q[i] || hold_d[i] <= DEB) begin
          rpt_d[i] = '0;
        end else if (rpt_q[i] == RPT_LAST) begin
          rpt_d[i]  = '0;
          rpt_ev[i] = 1'b1;
        end else begin
          rpt_d[i] = rpt_q[i] + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) rpt_q <= '0;
    else       rpt_q <= rpt_d;
  end

  assign up_ev = press[0] | rpt_ev[0];
  assign dn_ev = press[1] | rpt_ev[1];
`else
  assign up_ev = press[0];
  assign dn_ev = press[1];
`endif

  always_comb begin
    mode_d     = mode_q;
    register_d = register_q;
    x_d        = x_q;
    y_d        = y_q;
    if (tick) begin
      case (mode_q)
        VALUE, MOVE_X, MOVE_Y: begin
          if (press[2]) begin
            case (mode_q)
              VALUE:   mode_d = MOVE_X;
              MOVE_X:  mode_d = MOVE_Y;
              default: mode_d = VALUE;
            endcase
          end else if (up_ev ^ dn_ev) begin
            case (mode_q)
              VALUE:   register_d = up_ev ? register_q + 8'd1 : register_q - 8'd1;
              MOVE_X:  x_d = step_pos(x_q, up_ev, XLIM);
              default: y_d = step_pos(y_q, up_ev, YLIM);
            endcase
          end
        end
        default: mode_d = VALUE;
      endcase
    end
  end

  // Edge history resets high so an endframe already high at reset release gives no tick.
  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      ef_q       <= 1'b1;
      ef_prev_q  <= 1'b1;
      hold_q     <= '0;
      mode_q     <= VALUE;
      register_q <= '0;
      x_q        <= 10'(X_INIT);
      y_q        <= 10'(Y_INIT);
    end else begin
      sync1_q    <= {btn_sel, btn_down, btn_up};
      sync2_q    <= sync1_q;
      ef_q       <= endframe;
      ef_prev_q  <= ef_q;
      hold_q     <= hold_d;
      mode_q     <= mode_d;
      register_q <= register_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  assign register = register_q;
  assign x_pos    = x_q;
  assign y_pos    = y_q;
  assign mode     = mode_q;

endmodule

// File: tb/tb_reg_view_ctl.sv
// Scoreboard bench for reg_view_ctl: a frame-level model queues expected outputs, a monitor compares them.
module tb_reg_view_ctl;
  localparam int D  = 3;
  localparam int R  = 8;
  localparam int XI = 100;
  localparam int YI = 100;
  localparam int XM = 576;
  localparam int YM = 464;
  localparam int ST = 4;

  logic       px_clk = 1'b0;
  logic       reset, endframe, btn_up, btn_down, btn_sel;
  logic [7:0] register;
  logic [9:0] x_pos, y_pos;
  logic [1:0] mode;

  reg_view_ctl #(
    .DEBOUNCE_FRAMES(D), .REPEAT_FRAMES(R), .X_INIT(XI), .Y_INIT(YI),
    .X_MAX(XM), .Y_MAX(YM), .POS_STEP(ST)
  ) dut (
    .px_clk(px_clk), .reset(reset), .endframe(endframe),
    .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
    .register(register), .x_pos(x_pos), .y_pos(y_pos), .mode(mode)
  );

  always #5 px_clk = ~px_clk;

  int cyc = 0;
  always @(posedge px_clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int r;
    int x;
    int y;
    int m;
  } exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;

  // Reference state: outputs plus unbounded count of consecutive held ticks per button.
  int m_r, m_x, m_y, m_m;
  int held[3];

  task automatic push_state(input int at);
    exp_t e;
    e.cyc = at; e.r = m_r; e.x = m_x; e.y = m_y; e.m = m_m;
    q.push_back(e);
  endtask

  task automatic model_reset();
    m_r = 0; m_x = XI; m_y = YI; m_m = 0;
    for (int i = 0; i < 3; i++) held[i] = 0;
  endtask

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_tick(input bit u, input bit d, input bit s);
    bit lv[3];
    bit ev[3];
    int delta;
    lv[0] = u; lv[1] = d; lv[2] = s;
    for (int b = 0; b < 3; b++) begin
      held[b] = lv[b] ? held[b] + 1 : 0;
      ev[b] = (held[b] == D);
`ifdef REG_VIEW_AUTOREPEAT_EN
      if (b < 2 && held[b] > D && ((held[b] - D) % R) == 0) ev[b] = 1'b1;
`endif
    end
    if (ev[2]) begin
      m_m = (m_m + 1) % 3;
    end else if (ev[0] != ev[1]) begin
      delta = ev[0] ? 1 : -1;
      case (m_m)
        0:       m_r = (m_r + delta + 256) % 256;
        1:       m_x = clamp(m_x + delta * ST, XM);
        default: m_y = clamp(m_y + delta * ST, YM);
      endcase
    end
  endtask

  task automatic check(input string name, input int act, input int exp_v, input int at);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, at, act, exp_v);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge px_clk);
      #3;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        check("register", int'(register), e.r, e.cyc);
        check("x_pos",    int'(x_pos),    e.x, e.cyc);
        check("y_pos",    int'(y_pos),    e.y, e.cyc);
        check("mode",     int'(mode),     e.m, e.cyc);
      end
    end
  end

  // One frame: buttons settle through the synchronizer, then endframe rises for ef_len cycles.
  task automatic frame(input bit u, input bit d, input bit s, input int ef_len);
    int c;
    btn_up = u; btn_down = d; btn_sel = s;
    repeat (3) @(negedge px_clk);
    c = cyc;
    endframe = 1'b1;
    push_state(c + 1);
    model_tick(u, d, s);
    push_state(c + 2);
    if (ef_len > 2) push_state(c + ef_len);
    repeat (ef_len) @(negedge px_clk);
    endframe = 1'b0;
  endtask

  task automatic press(input bit u, input bit d, input bit s);
    repeat (D) frame(u, d, s, 1);
    frame(0, 0, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge px_clk);
    reset = 1'b1;
    model_reset();
    push_state(cyc + 1);
    repeat (3) @(negedge px_clk);
    reset = 1'b0;
  endtask

  initial begin
    bit ru, rd, rs;
    reset = 1'b1; endframe = 1'b1; btn_up = 1'b1; btn_down = 1'b0; btn_sel = 1'b0;
    model_reset();
    push_state(1);
    repeat (3) @(negedge px_clk);
    reset = 1'b0;
    // endframe high out of reset with up held: no tick may be counted.
    repeat (20) @(negedge px_clk);
    push_state(cyc + 1);
    endframe = 1'b0;
    btn_up = 1'b0;
    @(negedge px_clk);

    repeat (10) frame(0, 0, 0, 1);
    repeat (2) frame(1, 0, 0, 1);
    repeat (2) frame(0, 0, 0, 1);
    press(1, 0, 0);
    press(0, 1, 0);
    press(0, 1, 0);
    press(0, 0, 1);
    press(0, 0, 1);
    repeat (30) press(0, 1, 0);
    press(0, 0, 1);
    press(1, 0, 1);
    frame(0, 0, 0, 500);
    repeat (125) press(1, 0, 0);
    repeat (2) frame(1, 1, 0, 1);
    press(1, 1, 0);

    do_reset();
    repeat (27) frame(1, 0, 0, 1);
    frame(0, 0, 0, 1);

    do_reset();
    press(0, 0, 1);
    repeat (5) press(1, 0, 0);
    repeat (2) frame(1, 0, 0, 1);
    do_reset();
    repeat (3) frame(1, 0, 0, 1);
    frame(0, 0, 0, 1);

    ru = 0; rd = 0; rs = 0;
    repeat (300) begin
      if ($urandom_range(3, 0) == 0) ru = ~ru;
      if ($urandom_range(3, 0) == 0) rd = ~rd;
      if ($urandom_range(5, 0) == 0) rs = ~rs;
      frame(ru, rd, rs, int'($urandom_range(4, 1)));
    end
    frame(0, 0, 0, 1);

    repeat (10) @(negedge px_clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
